// File: rtl/reg_intf_cut.sv
// Register-interface pipeline cut: registers the request towards the slave and the
// response towards the master, with an optional watchdog that aborts hung transactions.
module reg_intf_cut #(
    parameter  int unsigned AddrWidth     = 32,
    parameter  int unsigned DataWidth     = 32,
    localparam int unsigned StrbWidth     = DataWidth / 8,
    parameter  int unsigned TimeoutCycles = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // upstream (master side of the cut)
    input  logic [AddrWidth-1:0] slv_addr_i,
    input  logic                 slv_write_i,
    input  logic [DataWidth-1:0] slv_wdata_i,
    input  logic [StrbWidth-1:0] slv_wstrb_i,
    input  logic                 slv_valid_i,
    output logic [DataWidth-1:0] slv_rdata_o,
    output logic                 slv_error_o,
    output logic                 slv_ready_o,
    // downstream (towards the register file)
    output logic [AddrWidth-1:0] mst_addr_o,
    output logic                 mst_write_o,
    output logic [DataWidth-1:0] mst_wdata_o,
    output logic [StrbWidth-1:0] mst_wstrb_o,
    output logic                 mst_valid_o,
    input  logic [DataWidth-1:0] mst_rdata_i,
    input  logic                 mst_error_i,
    input  logic                 mst_ready_i,
    // watchdog abort pulse and FSM state for observation
    output logic                 timeout_o,
    output logic [1:0]           dbg_state_o
);

    localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntWidth-1:0] CntLast =
        CntWidth'((TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0);

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Req  = 2'd1,
        Rsp  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q;
    logic                 write_q;
    logic [DataWidth-1:0] wdata_q;
    logic [StrbWidth-1:0] wstrb_q;
    logic [DataWidth-1:0] rdata_q;
    logic                 error_q;
    logic                 timeout_q;
    logic [CntWidth-1:0]  cnt_q;

    logic req_load;
    logic rsp_load;
    logic abort;
    logic cnt_inc;

    // Handshake: single phase, a transfer happens in any cycle where valid and ready are
    // both high; valid never waits on ready, and ready is only meaningful while valid is high.
    always_comb begin
        state_d  = state_q;
        req_load = 1'b0;
        rsp_load = 1'b0;
        abort    = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state_q)
            Idle: begin
                if (slv_valid_i) begin
                    req_load = 1'b1;
                    state_d  = Req;
                end
            end
            Req: begin
                // A real response beats the watchdog when both land in the same cycle.
                if (mst_ready_i) begin
                    rsp_load = 1'b1;
                    state_d  = Rsp;
                end else if ((TimeoutCycles != 0) && (cnt_q == CntLast)) begin
                    abort   = 1'b1;
                    state_d = Rsp;
                end else begin
                    cnt_inc = (TimeoutCycles != 0);
                end
            end
            Rsp: state_d = Idle;
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= Idle;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            timeout_q <= abort;
            if (req_load) begin
                addr_q  <= slv_addr_i;
                write_q <= slv_write_i;
                wdata_q <= slv_wdata_i;
                wstrb_q <= slv_wstrb_i;
                cnt_q   <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Read data is forwarded unmodified even on writes.
            if (rsp_load) begin
                rdata_q <= mst_rdata_i;
                error_q <= mst_error_i;
            end else if (abort) begin
                rdata_q <= '0;
                error_q <= 1'b1;
            end
        end
    end

    assign mst_valid_o = (state_q == Req);
    assign slv_ready_o = (state_q == Rsp);
    assign mst_addr_o  = addr_q;
    assign mst_write_o = write_q;
    assign mst_wdata_o = wdata_q;
    assign mst_wstrb_o = wstrb_q;
    assign slv_rdata_o = rdata_q;
    assign slv_error_o = error_q;
    assign timeout_o   = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reg_intf_cut.sv
// Bench for reg_intf_cut: directed and random transactions checked against a
// cycle-level reference of the expected response timing and contents.
module tb_reg_intf_cut;

    localparam int T = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // shared stimulus
    logic [31:0] slv_addr;
    logic        slv_write;
    logic [63:0] slv_wdata;
    logic [7:0]  slv_wstrb;
    logic        slv_valid;
    logic [63:0] mst_rdata;
    logic        mst_error;
    logic        mst_ready;
    logic        b_mst_ready;

    // DUT with watchdog (T=4)
    logic [63:0] slv_rdata;
    logic        slv_error, slv_ready;
    logic [31:0] mst_addr;
    logic        mst_write;
    logic [63:0] mst_wdata;
    logic [7:0]  mst_wstrb;
    logic        mst_valid, timeout;
    logic [1:0]  dbg_state;

    // DUT without watchdog (T=0)
    logic [63:0] b_slv_rdata;
    logic        b_slv_error, b_slv_ready;
    logic [31:0] b_mst_addr;
    logic        b_mst_write;
    logic [63:0] b_mst_wdata;
    logic [7:0]  b_mst_wstrb;
    logic        b_mst_valid, b_timeout;
    logic [1:0]  b_dbg_state;

    reg_intf_cut #(.AddrWidth(32), .DataWidth(64), .TimeoutCycles(T)) dut (
        .clk_i(clk), .rst_i(rst),
        .slv_addr_i(slv_addr), .slv_write_i(slv_write), .slv_wdata_i(slv_wdata),
        .slv_wstrb_i(slv_wstrb), .slv_valid_i(slv_valid),
        .slv_rdata_o(slv_rdata), .slv_error_o(slv_error), .slv_ready_o(slv_ready),
        .mst_addr_o(mst_addr), .mst_write_o(mst_write), .mst_wdata_o(mst_wdata),
        .mst_wstrb_o(mst_wstrb), .mst_valid_o(mst_valid),
        .mst_rdata_i(mst_rdata), .mst_error_i(mst_error), .mst_ready_i(mst_ready),
        .timeout_o(timeout), .dbg_state_o(dbg_state)
    );

    reg_intf_cut #(.AddrWidth(32), .DataWidth(64), .TimeoutCycles(0)) dut_nowd (
        .clk_i(clk), .rst_i(rst),
        .slv_addr_i(slv_addr), .slv_write_i(slv_write), .slv_wdata_i(slv_wdata),
        .slv_wstrb_i(slv_wstrb), .slv_valid_i(slv_valid),
        .slv_rdata_o(b_slv_rdata), .slv_error_o(b_slv_error), .slv_ready_o(b_slv_ready),
        .mst_addr_o(b_mst_addr), .mst_write_o(b_mst_write), .mst_wdata_o(b_mst_wdata),
        .mst_wstrb_o(b_mst_wstrb), .mst_valid_o(b_mst_valid),
        .mst_rdata_i(mst_rdata), .mst_error_i(mst_error), .mst_ready_i(b_mst_ready),
        .timeout_o(b_timeout), .dbg_state_o(b_dbg_state)
    );

    // scoreboard: {timeout, error, rdata} per upstream response
    logic [65:0] exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One upstream transaction against a slave that answers after n wait states.
    // Reference: response lands at cycle n+2 if n<T, else the watchdog answers at T+1.
    // Entered and left just after a rising edge, with the DUT idle.
    task automatic run_txn(input logic [31:0] a, input logic w, input logic [63:0] wd,
                           input logic [7:0] ws, input int n, input logic [63:0] rd,
                           input logic er);
        int          resp_cyc;
        logic [65:0] exp;
        resp_cyc = (n < T) ? n + 2 : T + 1;
        exp_q.push_back((n < T) ? {1'b0, er, rd} : {1'b1, 1'b1, 64'h0});
        for (int cyc = 0; cyc <= resp_cyc + 2; cyc++) begin
            slv_valid = (cyc == 0);
            if (cyc == 0) begin
                slv_addr = a; slv_write = w; slv_wdata = wd; slv_wstrb = ws;
            end else begin
                slv_addr  = $urandom;
                slv_write = 1'($urandom_range(0, 1));
                slv_wdata = {$urandom, $urandom};
                slv_wstrb = 8'($urandom_range(0, 255));
            end
            mst_ready = (cyc == n + 1);
            mst_rdata = (cyc == n + 1) ? rd : {$urandom, $urandom};
            mst_error = (cyc == n + 1) ? er : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (cyc >= 1 && cyc < resp_cyc) begin
                chk("req_valid", 66'(mst_valid), 66'(1));
                chk("req_addr", 66'(mst_addr), 66'(a));
                chk("req_write", 66'(mst_write), 66'(w));
                chk("req_wdata", 66'(mst_wdata), 66'(wd));
                chk("req_wstrb", 66'(mst_wstrb), 66'(ws));
                chk("req_no_ready", 66'(slv_ready), 66'(0));
            end else if (cyc == resp_cyc) begin
                chk("rsp_ready", 66'(slv_ready), 66'(1));
                chk("rsp_valid_low", 66'(mst_valid), 66'(0));
                if (exp_q.size() == 0) begin
                    chk("rsp_queue", 66'(0), 66'(1));
                end else begin
                    exp = exp_q.pop_front();
                    chk("rsp_payload", {timeout, slv_error, slv_rdata}, exp);
                end
            end else begin
                chk("idle_ready", 66'(slv_ready), 66'(0));
                chk("idle_valid", 66'(mst_valid), 66'(0));
                chk("idle_timeout", 66'(timeout), 66'(0));
            end
            @(posedge clk); #1;
        end
        mst_ready = 1'b0;
    endtask

    logic [31:0] bb_addr[3];
    logic [63:0] bb_rdata[3];
    logic [63:0] stall_rd;

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        // reset state
        rst = 1'b1;
        slv_addr = '0; slv_write = 1'b0; slv_wdata = '0; slv_wstrb = '0; slv_valid = 1'b0;
        mst_rdata = '0; mst_error = 1'b0; mst_ready = 1'b0; b_mst_ready = 1'b0;
        #3;
        chk("rst_ready", 66'(slv_ready), 66'(0));
        chk("rst_valid", 66'(mst_valid), 66'(0));
        chk("rst_rsp", {timeout, slv_error, slv_rdata}, 66'(0));
        chk("rst_req", 66'({mst_write, mst_wstrb, mst_addr}), 66'(0));
        chk("rst_wdata", 66'(mst_wdata), 66'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // directed cases
        run_txn(32'h40, 1'b0, 64'h0, 8'h00, 0, 64'hDEAD_BEEF_0123_4567, 1'b0);
        run_txn(32'h1000_0010, 1'b1, 64'hA5A5A5A5, 8'h0C, 3, 64'h1234_5678, 1'b1);
        run_txn(32'h88, 1'b0, 64'h0, 8'h00, 5, 64'hFFFF_0000_FFFF_0000, 1'b0);
        run_txn(32'h8C, 1'b0, 64'h0, 8'h00, T - 1, 64'h0BAD_CAFE_5555_AAAA, 1'b0);
        run_txn(32'h90, 1'b1, 64'h77, 8'hFF, T, 64'h1111, 1'b0);

        // random transactions, wait states straddling the watchdog limit
        for (int i = 0; i < 24; i++) begin
            run_txn($urandom, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                    8'($urandom_range(0, 255)), $urandom_range(0, 6),
                    {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        // back-to-back with slv_valid held high, zero-wait slave
        bb_addr[0] = 32'h100; bb_addr[1] = 32'h204; bb_addr[2] = 32'h308;
        bb_rdata[0] = 64'hA1; bb_rdata[1] = 64'hB2B2; bb_rdata[2] = 64'hC3C3C3;
        for (int cyc = 0; cyc <= 9; cyc++) begin
            int j;
            j = (cyc / 3 > 2) ? 2 : cyc / 3;
            slv_valid = (cyc <= 6);
            slv_addr = bb_addr[j]; slv_write = 1'b0; slv_wdata = '0; slv_wstrb = '0;
            mst_ready = 1'b1; mst_rdata = bb_rdata[j]; mst_error = 1'b0;
            @(negedge clk);
            chk("b2b_ready", 66'(slv_ready), 66'(cyc % 3 == 2 && cyc <= 8));
            if (cyc % 3 == 1) begin
                chk("b2b_valid", 66'(mst_valid), 66'(1));
                chk("b2b_addr", 66'(mst_addr), 66'(bb_addr[j]));
            end
            if (cyc % 3 == 2) begin
                chk("b2b_rdata", 66'(slv_rdata), 66'(bb_rdata[j]));
            end
            @(posedge clk); #1;
        end
        slv_valid = 1'b0; mst_ready = 1'b0;

        // reset in the middle of a request
        slv_valid = 1'b1; slv_addr = $urandom | 32'h1; slv_write = 1'b1;
        slv_wdata = {$urandom, $urandom} | 64'h1; slv_wstrb = 8'hFF;
        @(posedge clk); #1;
        slv_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_pre_valid", 66'(mst_valid), 66'(1));
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 66'(mst_valid), 66'(0));
        chk("mid_rst_ready", 66'(slv_ready), 66'(0));
        chk("mid_rst_rsp", {timeout, slv_error, slv_rdata}, 66'(0));
        chk("mid_rst_req", 66'({mst_write, mst_wstrb, mst_addr}), 66'(0));
        chk("mid_rst_wdata", 66'(mst_wdata), 66'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("post_rst_idle", 66'({mst_valid, slv_ready}), 66'(0));
            @(posedge clk); #1;
        end
        run_txn(32'h2468, 1'b0, 64'h0, 8'h00, 1, 64'h1357_9BDF, 1'b0);

        // no watchdog: a 100-cycle stall must never abort
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        stall_rd = {$urandom, $urandom};
        slv_valid = 1'b1; slv_addr = 32'hCAFE_0004; slv_write = 1'b0;
        b_mst_ready = 1'b0; mst_ready = 1'b0; mst_error = 1'b0;
        @(posedge clk); #1;
        slv_valid = 1'b0;
        for (int cyc = 1; cyc <= 101; cyc++) begin
            b_mst_ready = (cyc == 101);
            mst_rdata = stall_rd;
            @(negedge clk);
            chk("stall_req", 66'({b_mst_valid, b_slv_ready, b_timeout}), 66'(3'b100));
            if (cyc == 1) chk("stall_addr", 66'(b_mst_addr), 66'(32'hCAFE_0004));
            @(posedge clk); #1;
        end
        b_mst_ready = 1'b0;
        @(negedge clk);
        chk("stall_rsp", {b_timeout, b_slv_ready, b_slv_error, b_slv_rdata},
            {1'b0, 1'b1, 1'b0, stall_rd});
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_done", 66'({b_mst_valid, b_slv_ready}), 66'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
